// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults, product width and group-control FSM encoding for mac_responder
package mac_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int K_LEN_DEF  = 4;
    localparam int PROD_W     = 2 * DATA_W_DEF;
    typedef enum logic {IDLE, ACCUM} state_t;
endpackage

// File: rtl/mac_product_stage.sv
// mac_product_stage: registered multiplier holding product, valid, first and last tags
//   ports: clk, reset (sync, active-high); i_en beat valid; i_a/i_b operands;
//   i_first/i_last beat position tags; i_flush drops the held beat;
//   o_prod product; o_valid held beat not flushed; o_pending raw held-beat flag;
//   o_first/o_last tags of the held beat
module mac_product_stage #(
    parameter int DATA_W = mac_pkg::DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic                  i_flush,
    input  logic                  i_first,
    input  logic                  i_last,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic [2*DATA_W-1:0]   o_prod,
    output logic                  o_valid,
    output logic                  o_pending,
    output logic                  o_first,
    output logic                  o_last
);
    logic [2*DATA_W-1:0] r_prod;
    logic                r_valid;
    logic                r_first;
    logic                r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod  <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= i_en;
            if (i_en) begin
                r_prod  <= i_a * i_b;
                r_first <= i_first;
                r_last  <= i_last;
            end
        end
    end

    // A flush in the same cycle keeps the held beat out of the accumulator.
    assign o_valid   = r_valid & ~i_flush;
    assign o_pending = r_valid;
    assign o_prod    = r_prod;
    assign o_first   = r_first;
    assign o_last    = r_last;
endmodule

// File: rtl/mac_responder.sv
// mac_responder: pipelined multiply-accumulate, K_LEN products per dot-product result
//   ports: clk, reset (sync, active-high); enable_in operand beat valid; a_in/b_in operands;
//   acc_clear aborts the open group; mac_out last result (held); mac_valid 1-cycle update pulse;
//   mac_ovf overflow flag of the group on mac_out; busy group open or pipeline non-empty
//   MAC_SATURATE_EN: when defined, an overflowing group clamps to 2^ACC_W-1 instead of wrapping
module mac_responder
    import mac_pkg::*;
#(
    parameter int DATA_W = mac_pkg::DATA_W_DEF,
    parameter int ACC_W  = mac_pkg::ACC_W_DEF,
    parameter int K_LEN  = mac_pkg::K_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              acc_clear,
    output logic [ACC_W-1:0]  mac_out,
    output logic              mac_valid,
    output logic              mac_ovf,
    output logic              busy
);
    localparam int CNT_W = K_LEN > 1 ? $clog2(K_LEN) : 1;
    localparam int P_W   = 2 * DATA_W;
    // Sum is wide enough for both a carry out of ACC_W and a product wider than ACC_W.
    localparam int S_W   = (P_W > ACC_W ? P_W : ACC_W) + 1;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt, w_cnt_nxt;
    logic             w_first, w_last;
    logic [P_W-1:0]   w_s1_prod;
    logic             w_s1_valid, w_s1_pending, w_s1_first, w_s1_last;
    logic             r_s2_valid;
    logic [ACC_W-1:0] r_acc, w_base, w_acc_nxt;
    logic             r_gov, w_gov, w_carry;
    logic [S_W-1:0]   w_sum;

    // acc_clear with enable_in makes this beat beat 0 of a fresh group.
    assign w_cnt   = acc_clear ? '0 : r_cnt;
    assign w_first = w_cnt == '0;
    assign w_last  = w_cnt == CNT_W'(K_LEN - 1);

    always_comb begin
        w_cnt_nxt   = enable_in ? (w_last ? '0 : w_cnt + 1'b1) : w_cnt;
        w_state_nxt = enable_in ? (w_last ? IDLE : ACCUM) : (acc_clear ? IDLE : r_state);
    end

    mac_product_stage #(.DATA_W(DATA_W)) u_prod (
        .clk       (clk),
        .reset     (reset),
        .i_en      (enable_in),
        .i_flush   (acc_clear),
        .i_first   (w_first),
        .i_last    (w_last),
        .i_a       (a_in),
        .i_b       (b_in),
        .o_prod    (w_s1_prod),
        .o_valid   (w_s1_valid),
        .o_pending (w_s1_pending),
        .o_first   (w_s1_first),
        .o_last    (w_s1_last)
    );

    assign w_base  = w_s1_first ? '0 : r_acc;
    assign w_sum   = S_W'(w_base) + S_W'(w_s1_prod);
    assign w_carry = |w_sum[S_W-1:ACC_W];
    assign w_gov   = (~w_s1_first & r_gov) | w_carry;
`ifdef MAC_SATURATE_EN
    assign w_acc_nxt = w_gov ? '1 : w_sum[ACC_W-1:0];
`else
    assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_s2_valid <= 1'b0;
            r_acc      <= '0;
            r_gov      <= 1'b0;
            mac_out    <= '0;
            mac_valid  <= 1'b0;
            mac_ovf    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_s2_valid <= w_s1_valid;
            mac_valid  <= w_s1_valid & w_s1_last;
            if (w_s1_valid) begin
                r_acc <= w_acc_nxt;
                r_gov <= w_gov;
            end
            if (w_s1_valid & w_s1_last) begin
                mac_out <= w_acc_nxt;
                mac_ovf <= w_gov;
            end
        end
    end

    assign busy = (r_state == ACCUM) | w_s1_pending | r_s2_valid;
endmodule

// File: tb/tb_mac_responder.sv
// tb_mac_responder: randomized and directed checks of mac_responder against a group-level model
module tb_mac_responder;
    import mac_pkg::*;
    localparam int DW = DATA_W_DEF;
    localparam int AW = ACC_W_DEF;
    localparam int K  = K_LEN_DEF;
`ifdef MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable_in = 1'b0;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] b_in = '0;
    logic          acc_clear = 1'b0;
    logic [AW-1:0] mac_out;
    logic          mac_valid;
    logic          mac_ovf;
    logic          busy;

    always #5 clk = ~clk;

    mac_responder #(.DATA_W(DW), .ACC_W(AW), .K_LEN(K)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable_in (enable_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .acc_clear (acc_clear),
        .mac_out   (mac_out),
        .mac_valid (mac_valid),
        .mac_ovf   (mac_ovf),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;

    // Model: open group as a queue of products; a finished group's result is due
    // one edge later unless acc_clear flushes it first.
    longint q[$];
    logic   pend_v = 1'b0;
    longint pend_out = 0;
    logic   pend_ovf = 1'b0;
    logic   prev_en = 1'b0;
    longint m_out = 0;
    logic   m_ovf = 1'b0;
    logic   m_valid = 1'b0;
    logic   m_busy = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        reset = r; enable_in = e; acc_clear = c; a_in = a; b_in = b;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            pend_v = 1'b0; prev_en = 1'b0;
            m_out = 0; m_ovf = 1'b0; m_valid = 1'b0; m_busy = 1'b0;
        end else begin
            m_valid = pend_v & ~c;
            if (m_valid) begin
                m_out = pend_out;
                m_ovf = pend_ovf;
            end
            pend_v = 1'b0;
            if (c) q.delete();
            if (e) begin
                q.push_back(longint'(a) * longint'(b));
                if (q.size() == K) begin
                    longint t;
                    t = 0;
                    foreach (q[i]) t += q[i];
                    pend_ovf = t >= (longint'(1) << AW);
                    pend_out = pend_ovf ? (SAT ? (longint'(1) << AW) - 1 : t % (longint'(1) << AW)) : t;
                    pend_v = 1'b1;
                    q.delete();
                end
            end
            m_busy = (q.size() > 0) || e || (prev_en && !c);
            prev_en = e;
        end
        if (mac_valid === 1'b1) n_valid++;
        check("valid", 64'(mac_valid), 64'(m_valid));
        check("out", 64'(mac_out), 64'(m_out));
        check("ovf", 64'(mac_ovf), 64'(m_ovf));
        check("busy", 64'(busy), 64'(m_busy));
    endtask

    task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b);
        step(1'b0, 1'b1, 1'b0, a, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int nv;
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0, 8'd9, 8'd9);
        step(1'b1, 1'b1, 1'b0, 8'd7, 8'd3);
        check("rst_out", 64'(mac_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        nv = n_valid;
        idle(4);
        check("rst_novalid", 64'(n_valid - nv), 64'd0);

        beat(8'd1, 8'd1); beat(8'd2, 8'd4); beat(8'd3, 8'd1); beat(8'd4, 8'd3);
        idle(1);
        check("single_valid", 64'(mac_valid), 64'd1);
        check("single_out", 64'(mac_out), 64'd24);
        idle(2);

        nv = n_valid;
        beat(8'd1, 8'd1); idle(2); beat(8'd2, 8'd4); idle(2);
        beat(8'd3, 8'd1); idle(2); beat(8'd4, 8'd3);
        idle(1);
        check("gap_out", 64'(mac_out), 64'd24);
        idle(3);
        check("gap_pulses", 64'(n_valid - nv), 64'd1);

        nv = n_valid;
        for (int i = 0; i < K; i++) beat(8'd1, 8'd1);
        for (int i = 0; i < K; i++) begin
            beat(8'd2, 8'd3);
            if (i == 0) check("b2b_first", 64'(mac_out), 64'd4);
        end
        idle(1);
        check("b2b_second", 64'(mac_out), 64'd24);
        idle(2);
        check("b2b_pulses", 64'(n_valid - nv), 64'd2);

        for (int i = 0; i < K; i++) beat(8'd255, 8'd255);
        idle(1);
        check("ovf_flag", 64'(mac_ovf), 64'd1);
        check("ovf_out", 64'(mac_out), SAT ? 64'd65535 : 64'd63492);
        idle(2);

        beat(8'd3, 8'd3); beat(8'd4, 8'd4);
        step(1'b0, 1'b1, 1'b1, 8'd5, 8'd5);
        check("abort_hold", 64'(mac_out), SAT ? 64'd65535 : 64'd63492);
        beat(8'd1, 8'd1); beat(8'd1, 8'd1); beat(8'd1, 8'd1);
        idle(1);
        check("abort_out", 64'(mac_out), 64'd28);
        check("abort_ovf", 64'(mac_ovf), 64'd0);
        idle(2);

        nv = n_valid;
        beat(8'd6, 8'd6); beat(8'd7, 8'd7);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        idle(4);
        check("rst_mid_novalid", 64'(n_valid - nv), 64'd0);
        check("rst_mid_out", 64'(mac_out), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            logic r, e, c;
            logic [DW-1:0] a, b;
            r = $urandom_range(0, 299) == 0;
            e = $urandom_range(0, 99) < 65;
            c = $urandom_range(0, 99) < 5;
            a = $urandom_range(0, 1) ? DW'($urandom) : DW'($urandom_range(0, 15));
            b = $urandom_range(0, 1) ? DW'($urandom) : DW'($urandom_range(0, 15));
            step(r, e, c, a, b);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
